// File: rtl/execute_cycle.sv
// execute_cycle: RV32I execute stage with operand forwarding, ALU, branch
// resolution and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_E,
    input  logic              MemWrite_E,
    input  logic              ResultSrc_E,
    input  logic              Branch_E,
    input  logic              ALUSrc_E,
    input  logic              valid_E,
    input  logic [2:0]        ALUControl_E,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PC_E,
    input  logic [XLEN-1:0]   PCPlus4_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic [XLEN-1:0]   Result_W,
    input  logic              stall_M,
    input  logic              flush_M,
    output logic              PCSrc_E,
    output logic [XLEN-1:0]   PCTarget_E,
    output logic              RegWrite_M,
    output logic              MemWrite_M,
    output logic              ResultSrc_M,
    output logic              valid_M,
    output logic [XLEN-1:0]   ALUResult_M,
    output logic [XLEN-1:0]   WriteData_M,
    output logic [XLEN-1:0]   PCPlus4_M,
    output logic [REG_AW-1:0] Rd_M
);
    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
    logic            zero;

    // Select 11 falls through to the register-file value, same as 00
    always_comb begin
        src_a = ForwardA_E == 2'b01 ? Result_W : ForwardA_E == 2'b10 ? ALUResult_M : RD1_E;
        fwd_b = ForwardB_E == 2'b01 ? Result_W : ForwardB_E == 2'b10 ? ALUResult_M : RD2_E;
        src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;
        alu_result = src_b;
        case (ALUControl_E)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = src_a - src_b;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = src_a ^ src_b;
            3'b101: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            3'b110: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            3'b111: alu_result = src_b;
        endcase
    end

    assign zero       = alu_result == '0;
    assign PCSrc_E    = Branch_E & zero & valid_E;
    assign PCTarget_E = PC_E + Imm_Ext_E;

    // Flush outranks stall; bubbles never carry write enables forward
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= 1'b0;
            valid_M     <= 1'b0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
            Rd_M        <= '0;
        end else if (flush_M) begin
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= 1'b0;
            valid_M     <= 1'b0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
            Rd_M        <= '0;
        end else if (!stall_M) begin
            RegWrite_M  <= RegWrite_E & valid_E;
            MemWrite_M  <= MemWrite_E & valid_E;
            ResultSrc_M <= ResultSrc_E & valid_E;
            valid_M     <= valid_E;
            ALUResult_M <= alu_result;
            WriteData_M <= fwd_b;
            PCPlus4_M   <= PCPlus4_E;
            Rd_M        <= Rd_E;
        end
    end
endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline. Sits directly downstream of the decode stage's ID/EX register and upstream of the memory stage.
- Selects forwarded operands and computes the ALU result and zero flag.
- Resolves branches: produces PCSrc_E and PCTarget_E for the fetch stage.
- Registers results and control into the EX/MEM pipeline register, with stall and flush.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E, ALUSrc_E  in  1 each  control from ID/EX
- valid_E  in  1  instruction in EX is real (0 = bubble)
- ALUControl_E  in  3  ALU op select
- RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E  in  XLEN each  ID/EX data
- Rd_E  in  REG_AW  destination register
- ForwardA_E, ForwardB_E  in  2 each  00 = RDx_E, 01 = Result_W, 10 = ALUResult_M, 11 = RDx_E
- Result_W  in  XLEN  writeback value for forwarding
- stall_M  in  1  hold EX/MEM register
- flush_M  in  1  insert bubble into EX/MEM
- PCSrc_E  out  1  branch taken, combinational
- PCTarget_E  out  XLEN  branch target, combinational
- RegWrite_M, MemWrite_M, ResultSrc_M, valid_M  out  1 each  registered control
- ALUResult_M, WriteData_M, PCPlus4_M  out  XLEN each  registered data
- Rd_M  out  REG_AW  registered destination

Behaviour:
- Operand selection:
  - SrcA = forward mux(ForwardA_E) over RD1_E.
  - fwdB = forward mux(ForwardB_E) over RD2_E.
  - SrcB = ALUSrc_E ? Imm_Ext_E : fwdB.
  - ALUResult_M is the registered output fed back internally.
- ALU ops, all mod 2^XLEN, wrap silently:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SLT signed (result 1/0, zero-extended), 110 SLTU unsigned, 111 pass SrcB
- Zero = (ALU result == 0).
- PCTarget_E = PC_E + Imm_Ext_E, mod 2^XLEN.
- PCSrc_E = Branch_E & Zero & valid_E. Combinational, same cycle as EX; no registered delay.
- Latency: one cycle EX -> M for all registered outputs.
- EX/MEM register, per rising edge, in priority order:
  1. flush_M = 1: RegWrite_M, MemWrite_M, ResultSrc_M, valid_M <= 0. ALUResult_M, WriteData_M, PCPlus4_M, Rd_M <= 0. flush_M wins over stall_M.
  2. stall_M = 1: all M outputs hold.
  3. Otherwise: capture.
     - ALUResult_M <= ALU result.
     - WriteData_M <= fwdB (forwarded, not immediate).
     - Rd_M <= Rd_E; PCPlus4_M <= PCPlus4_E.
     - Control and valid_M <= E value gated by valid_E: a bubble (valid_E = 0) never writes the register file or memory.
- Reset:
  - rst low asynchronously clears every registered output to 0, regardless of clk, stall or flush.
  - Combinational outputs follow their inputs during reset.
  - Deassertion is synchronised externally; first capture is on the first rising edge with rst high.
  - Reset mid-stall discards the held instruction.
- Forward select 11 behaves as 00.
- Forwarding from ALUResult_M uses the current registered value, including while stall_M holds it.
- WriteData_M carries fwdB even for non-store ops.

Test Plan:
- ADD with forward, no stall: RD1_E=5, RD2_E=7, ALUSrc_E=0, ALUControl_E=000, Rd_E=3, valid_E=1 -> next edge ALUResult_M=12, Rd_M=3, valid_M=1.
- Wrap and signed compare: SUB with 0 - 1 -> ALUResult_M=0xFFFFFFFF. SLT(0xFFFFFFFF, 1) -> 1. SLTU of the same -> 0.
- Branch: Branch_E=1, SUB 9 - 9, PC_E=0x100, Imm_Ext_E=0xFFFFFFF0 -> PCSrc_E=1 and PCTarget_E=0xF0 in the same cycle. With valid_E=0 -> PCSrc_E=0.
- Forwarding: ForwardA_E=10 with ALUResult_M=0x20, and ForwardB_E=01 with Result_W=0x4, op ADD -> 0x24 captured. Store with ALUSrc_E=1, Imm_Ext_E=8 -> WriteData_M=0x4.
- Stall/flush: stall_M=1 for 2 cycles -> M outputs unchanged. flush_M=stall_M=1 -> RegWrite_M=MemWrite_M=valid_M=0 and all data 0.
- Async reset mid-operation: drive rst low between edges -> all M outputs 0 immediately. Release -> first capture on next edge.
